// File: rtl/picobus_pkg.sv
// picobus_pkg: shared state encoding, error defaults and helpers for the picobus fabric
package picobus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/picobus_addr_decode.sv
// picobus_addr_decode: priority address-byte decoder, lowest matching slot wins
module picobus_addr_decode #(
  parameter int NUM_SLAVES = 4
) (
  input  logic [7:0]              addr_byte,
  input  logic [NUM_SLAVES*8-1:0] slave_base,
  output logic                    hit,
  output logic [NUM_SLAVES-1:0]   sel
);
  // scan from the top slot down so a lower matching slot overwrites a higher one
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_byte == slave_base[8*i+:8]) begin
        sel = NUM_SLAVES'(1) << i;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/picobus_fabric.sv
// picobus_fabric: picorv32 native bus to NUM_SLAVES slot interconnect with timeout and error reporting
module picobus_fabric
  import picobus_pkg::*;
#(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_BASE     = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic                     mem_instr,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_instr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t                  state_q, state_d;
  logic                    skip_q, skip_d;
  logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic                    s_instr_q, s_instr_d;
  logic [31:0]             s_addr_q, s_addr_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic [3:0]              s_wstrb_q, s_wstrb_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             err_addr_q, err_addr_d;
  logic [7:0]              err_count_q, err_count_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dec_hit;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic [31:0]             sel_rdata;
  logic                    sel_ready;
  logic                    timeout_hit;
  picobus_addr_decode #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
    .addr_byte (mem_addr[31:24]),
    .slave_base(SLAVE_BASE),
    .hit       (dec_hit),
    .sel       (dec_sel)
  );
  // s_valid_q doubles as the one-hot slot select while a transfer is active
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel_rdata = sel_rdata | (s_valid_q[i] ? s_rdata[32*i+:32] : 32'h0);
  end
  assign sel_ready   = |(s_ready & s_valid_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  // next-state, request capture, timeout counting and error statistics
  always_comb begin
    state_d     = state_q;
    skip_d      = 1'b0;
    s_valid_d   = s_valid_q;
    s_instr_d   = s_instr_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    rdata_d     = rdata_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && !skip_q) begin
          s_instr_d = mem_instr;
          s_addr_d  = mem_addr;
          s_wdata_d = mem_wdata;
          s_wstrb_d = mem_wstrb;
          s_valid_d = dec_sel;
          cnt_d     = '0;
          rdata_d   = dec_hit ? rdata_q : ERR_RDATA;
          state_d   = dec_hit ? ST_ACTIVE : ST_ERROR;
        end
      end
      ST_ACTIVE: begin
        if (sel_ready) begin
          rdata_d   = sel_rdata;
          s_valid_d = '0;
          state_d   = ST_RESPOND;
        end else if (timeout_hit) begin
          rdata_d   = ERR_RDATA;
          s_valid_d = '0;
          state_d   = ST_ERROR;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        skip_d  = 1'b1;
      end
      ST_ERROR: begin
        state_d     = ST_IDLE;
        skip_d      = 1'b1;
        err_addr_d  = s_addr_q;
        err_count_d = sat_inc8(err_count_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any in-flight transfer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      skip_q      <= 1'b0;
      s_valid_q   <= '0;
      s_instr_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      s_valid_q   <= s_valid_d;
      s_instr_q   <= s_instr_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      rdata_q     <= rdata_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
      cnt_q       <= cnt_d;
    end
  end
  assign mem_ready = (state_q == ST_RESPOND) || (state_q == ST_ERROR);
  assign bus_err   = (state_q == ST_ERROR);
  assign mem_rdata = rdata_q;
  assign s_valid   = s_valid_q;
  assign s_instr   = s_instr_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
endmodule
